// File: rtl/scpu_port_pkg.sv
// Shared constants and types for the SCPU external byte port.
// Defines default data width, queue depth, byte type and ext_in reset value.
package scpu_port_pkg;

    localparam int SCPU_WIDTH = 8;
    localparam int SCPU_DEPTH = 4;

    typedef logic [SCPU_WIDTH-1:0] byte_t;

    localparam byte_t EXT_IN_RST = '0;

endpackage

// File: rtl/scpu_ext_port_if.sv
// Byte I/O bundle between SCPU/host (master) and the external port (slave).
// Carries host input handshake, CPU ext_in/ext_out strobes, host output handshake, flags.
interface scpu_ext_port_if
    import scpu_port_pkg::*;
#(
    parameter int WIDTH = SCPU_WIDTH
) ();

    logic             host_in_valid;
    logic [WIDTH-1:0] host_in_data;
    logic             host_in_ready;
    logic [WIDTH-1:0] ext_in;
    logic             in_rd;
    logic             in_empty;
    logic [WIDTH-1:0] ext_out;
    logic             out_wr;
    logic             host_out_valid;
    logic [WIDTH-1:0] host_out_data;
    logic             host_out_ready;
    logic             in_underflow;
    logic             out_overflow;

    modport master (
        output host_in_valid, host_in_data, in_rd,
        output ext_out, out_wr, host_out_ready,
        input  host_in_ready, ext_in, in_empty,
        input  host_out_valid, host_out_data,
        input  in_underflow, out_overflow
    );

    modport slave (
        input  host_in_valid, host_in_data, in_rd,
        input  ext_out, out_wr, host_out_ready,
        output host_in_ready, ext_in, in_empty,
        output host_out_valid, host_out_data,
        output in_underflow, out_overflow
    );

endinterface

// File: rtl/scpu_port_fifo.sv
// Synchronous circular FIFO; caller qualifies i_push/i_pop against full/empty.
// Ports: clk, rst (async low), i_push, i_pop, i_din, o_full, o_empty, o_count, o_head.
module scpu_port_fifo
    import scpu_port_pkg::*;
#(
    parameter int WIDTH    = SCPU_WIDTH,
    parameter int DEPTH    = SCPU_DEPTH,
    parameter bit REG_HEAD = 1'b1,
    localparam int CNT_W   = $clog2(DEPTH) + 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (i_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    generate
        if (REG_HEAD) begin : g_reg_head
            // Head lags the queue by one edge and keeps the last value once empty.
            logic [WIDTH-1:0] r_head;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_head <= WIDTH'(EXT_IN_RST);
                end else if (r_count != '0) begin
                    r_head <= r_mem[r_rd];
                end
            end
            assign o_head = r_head;
        end else begin : g_comb_head
            assign o_head = o_empty ? '0 : r_mem[r_rd];
        end
    endgenerate

endmodule

// File: rtl/scpu_ext_port.sv
// External-side SCPU byte port: host->ext_in queue and ext_out->host capture queue.
// Ports: clk, rst (async low), bus (scpu_ext_port_if.slave). Option: SCPU_PORT_CHANGE_CAPTURE_EN.
module scpu_ext_port
    import scpu_port_pkg::*;
#(
    parameter int WIDTH  = SCPU_WIDTH,
    parameter int DEPTH  = SCPU_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    scpu_ext_port_if.slave bus
);

    logic             w_in_full;
    logic             w_in_empty;
    logic [CNT_W-1:0] w_in_cnt;
    logic             w_in_push;
    logic             w_in_pop;

    logic             w_out_full;
    logic             w_out_empty;
    logic [CNT_W-1:0] w_out_cnt;
    logic             w_out_push;
    logic             w_out_pop;
    logic             w_trig;

    logic             r_underflow;
    logic             r_overflow;

    // Input side: a same-cycle pop never makes room for a push.
    assign w_in_push = bus.host_in_valid && !w_in_full;
    assign w_in_pop  = bus.in_rd && !w_in_empty;

    scpu_port_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .REG_HEAD (1'b1)
    ) u_in_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_in_push),
        .i_pop   (w_in_pop),
        .i_din   (bus.host_in_data),
        .o_full  (w_in_full),
        .o_empty (w_in_empty),
        .o_count (w_in_cnt),
        .o_head  (bus.ext_in)
    );

    assign bus.host_in_ready = (w_in_cnt != CNT_W'(DEPTH));
    assign bus.in_empty      = w_in_empty;

`ifdef SCPU_PORT_CHANGE_CAPTURE_EN
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= bus.ext_out;
        end
    end

    assign w_trig = bus.out_wr || (bus.ext_out != r_prev);
`else
    assign w_trig = bus.out_wr;
`endif

    // Output side: a host pop in the same cycle frees the slot for the capture.
    assign w_out_pop  = bus.host_out_ready && !w_out_empty;
    assign w_out_push = w_trig && (!w_out_full || w_out_pop);

    scpu_port_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .REG_HEAD (1'b0)
    ) u_out_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_out_push),
        .i_pop   (w_out_pop),
        .i_din   (bus.ext_out),
        .o_full  (w_out_full),
        .o_empty (w_out_empty),
        .o_count (w_out_cnt),
        .o_head  (bus.host_out_data)
    );

    assign bus.host_out_valid = (w_out_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (bus.in_rd && w_in_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_trig && !w_out_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.in_underflow = r_underflow;
    assign bus.out_overflow = r_overflow;

endmodule

// File: tb/tb_scpu_ext_port.sv
// Randomized and directed bench for scpu_ext_port against a queue-based model.
// Honours SCPU_PORT_CHANGE_CAPTURE_EN the same way as the design.
module tb_scpu_ext_port;
    import scpu_port_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    scpu_ext_port_if #(.WIDTH(W)) bus ();

    scpu_ext_port #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] in_q[$];
    logic [W-1:0] out_q[$];
    logic [W-1:0] m_ext_in;
    logic [W-1:0] m_prev;
    bit           m_unf;
    bit           m_ovf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_ext_in = '0;
        m_prev   = '0;
        m_unf    = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // Applies one clock edge of behaviour using the inputs held across it.
    task automatic model_edge();
        int  in_n;
        int  out_n;
        bit  opop;
        bit  trig;
        in_n  = in_q.size();
        out_n = out_q.size();
        // ext_in shows what was at the queue head one cycle earlier.
        if (in_n > 0) m_ext_in = in_q[0];
        if (bus.in_rd && in_n == 0) m_unf = 1'b1;
        if (bus.in_rd && in_n > 0) void'(in_q.pop_front());
        if (bus.host_in_valid && in_n < D) in_q.push_back(bus.host_in_data);
        opop = bus.host_out_ready && out_n > 0;
        trig = bus.out_wr;
`ifdef SCPU_PORT_CHANGE_CAPTURE_EN
        if (bus.ext_out != m_prev) trig = 1'b1;
`endif
        m_prev = bus.ext_out;
        if (opop) void'(out_q.pop_front());
        if (trig) begin
            if (out_n < D || opop) out_q.push_back(bus.ext_out);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("ext_in", bus.ext_in, m_ext_in);
        chk("in_empty", bus.in_empty, in_q.size() == 0);
        chk("host_in_ready", bus.host_in_ready, in_q.size() != D);
        chk("host_out_valid", bus.host_out_valid, out_q.size() != 0);
        if (out_q.size() != 0)
            chk("host_out_data", bus.host_out_data, out_q[0]);
        chk("in_underflow", bus.in_underflow, m_unf);
        chk("out_overflow", bus.out_overflow, m_ovf);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_ext_in"}, bus.ext_in, 0);
        chk({tag, "_in_empty"}, bus.in_empty, 1);
        chk({tag, "_in_ready"}, bus.host_in_ready, 1);
        chk({tag, "_out_valid"}, bus.host_out_valid, 0);
        chk({tag, "_out_data"}, bus.host_out_data, 0);
        chk({tag, "_unf"}, bus.in_underflow, 0);
        chk({tag, "_ovf"}, bus.out_overflow, 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bus.host_in_valid  = 1'b0;
        bus.host_in_data   = '0;
        bus.in_rd          = 1'b0;
        bus.ext_out        = '0;
        bus.out_wr         = 1'b0;
        bus.host_out_ready = 1'b0;
        model_reset();
        #12;
        reset_check("rst0");
        @(negedge clk);
        rst = 1'b1;
        check_all();

        // Input queue basic flow
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 8'h0F;
        step();
        chk("t1_ext_in_lag", bus.ext_in, 8'h00);
        bus.host_in_data = 8'h22;
        step();
        chk("t1_ext_in_0f", bus.ext_in, 8'h0F);
        chk("t1_ready", bus.host_in_ready, 1);
        bus.host_in_valid = 1'b0;
        bus.in_rd = 1'b1;
        step();
        bus.in_rd = 1'b0;
        step();
        chk("t1_ext_in_22", bus.ext_in, 8'h22);
        bus.in_rd = 1'b1;
        step();
        bus.in_rd = 1'b0;
        chk("t1_empty", bus.in_empty, 1);
        step();
        chk("t1_hold", bus.ext_in, 8'h22);

        // Fill the input queue, then pop while full
        bus.host_in_valid = 1'b1;
        for (int i = 1; i <= D; i++) begin
            bus.host_in_data = 8'(i);
            step();
        end
        chk("t2_not_ready", bus.host_in_ready, 0);
        bus.host_in_data = 8'h05;
        step();
        chk("t2_still_full", bus.host_in_ready, 0);
        bus.in_rd = 1'b1;
        step();
        chk("t2_ready_after_pop", bus.host_in_ready, 1);
        bus.host_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("t2_drained", bus.in_empty, 1);

        // Underflow
        step();
        bus.in_rd = 1'b0;
        chk("t3_unf", bus.in_underflow, 1);
        chk("t3_ext_in_hold", bus.ext_in, 8'h04);
        step();
        chk("t3_unf_sticky", bus.in_underflow, 1);

        // Output capture with back-pressure
        bus.out_wr  = 1'b1;
        bus.ext_out = 8'hA5;
        step();
        bus.ext_out = 8'h3C;
        step();
        bus.out_wr = 1'b0;
        step();
        chk("t4_valid", bus.host_out_valid, 1);
        chk("t4_data_a5", bus.host_out_data, 8'hA5);
        step();
        chk("t4_data_held", bus.host_out_data, 8'hA5);
        bus.host_out_ready = 1'b1;
        step();
        chk("t4_data_3c", bus.host_out_data, 8'h3C);
        step();
        chk("t4_valid_low", bus.host_out_valid, 0);
        bus.host_out_ready = 1'b0;

        // Output overflow drops the byte
        bus.out_wr = 1'b1;
        for (int i = 0; i < D; i++) begin
            bus.ext_out = 8'h41 + 8'(i);
            step();
        end
        bus.ext_out = 8'h77;
        step();
        bus.out_wr = 1'b0;
        chk("t5_ovf", bus.out_overflow, 1);
        chk("t5_head", bus.host_out_data, 8'h41);
        bus.host_out_ready = 1'b1;
        for (int i = 0; i < D; i++) step();
        chk("t5_no_77", bus.host_out_valid, 0);
        bus.host_out_ready = 1'b0;

        // Capture while full but popping is kept
        bus.out_wr = 1'b1;
        for (int i = 0; i < D; i++) begin
            bus.ext_out = 8'h51 + 8'(i);
            step();
        end
        bus.host_out_ready = 1'b1;
        bus.ext_out = 8'h77;
        step();
        bus.out_wr = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("t5b_kept_77", bus.host_out_data, 8'h77);
        step();
        chk("t5b_empty", bus.host_out_valid, 0);
        bus.host_out_ready = 1'b0;

        // Change-detect capture
        bus.ext_out = 8'h00;
        step();
        bus.host_out_ready = 1'b1;
        step();
        bus.host_out_ready = 1'b0;
        bus.ext_out = 8'h10;
        step();
        step();
        bus.ext_out = 8'h20;
        step();
`ifdef SCPU_PORT_CHANGE_CAPTURE_EN
        chk("t6_valid", bus.host_out_valid, 1);
        chk("t6_data_10", bus.host_out_data, 8'h10);
        bus.host_out_ready = 1'b1;
        step();
        chk("t6_data_20", bus.host_out_data, 8'h20);
        step();
        chk("t6_done", bus.host_out_valid, 0);
        bus.host_out_ready = 1'b0;
`else
        chk("t6_none", bus.host_out_valid, 0);
`endif

        // Asynchronous reset with data in flight
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 8'hAA;
        step();
        bus.host_in_data = 8'hBB;
        step();
        bus.host_in_valid = 1'b0;
        bus.out_wr  = 1'b1;
        bus.ext_out = 8'hC1;
        step();
        bus.ext_out = 8'hC2;
        step();
        bus.out_wr  = 1'b0;
        bus.ext_out = 8'h00;
        #2 rst = 1'b0;
        #1 reset_check("t7");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        check_all();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            bus.host_in_valid  = 1'($urandom_range(0, 1));
            bus.host_in_data   = 8'($urandom);
            bus.in_rd          = ($urandom_range(0, 2) == 0);
            bus.out_wr         = ($urandom_range(0, 2) == 0);
            bus.host_out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) bus.ext_out = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scpu_ext_port.md
Name: scpu_ext_port

Overview:
External-side peripheral for the SCPU byte I/O interface: the other end of ext_in/ext_out. It queues host-supplied bytes and presents them on the CPU's ext_in one at a time, advancing on a CPU read strobe. It captures bytes the CPU writes on ext_out into an output queue that a host or bench drains over a valid/ready handshake. It sits between SCPU and the testbench or board-level I/O, and replaces the fixed constant input.

Parameters:
WIDTH, 8, data width of ext_in/ext_out and host bytes
DEPTH, 4, entries per queue; power of two, >=2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
host_in_valid  input  1  host byte offered
host_in_data  input  WIDTH  host byte
host_in_ready  output  1  input queue can accept
ext_in  output  WIDTH  byte presented to SCPU ext_in
in_rd  input  1  one-cycle CPU strobe: current ext_in consumed
in_empty  output  1  input queue empty
ext_out  input  WIDTH  SCPU ext_out
out_wr  input  1  one-cycle CPU strobe: ext_out valid this cycle
host_out_valid  output  1  captured byte available
host_out_data  output  WIDTH  oldest captured byte
host_out_ready  input  1  host accepts captured byte
in_underflow  output  1  sticky: in_rd while input queue empty
out_overflow  output  1  sticky: capture dropped, output queue full

Behaviour:
- Reset (rst=0, async): both queues empty; ext_in=0; host_in_ready=1; in_empty=1; host_out_valid=0; host_out_data=0; both sticky flags 0. Reset mid-transfer discards all queued data.
- Input queue: circular buffer with wr/rd pointers wrapping modulo DEPTH and a CNT_W-bit count. host_in_ready = (count != DEPTH), combinational from registered count. A push happens when valid && ready. A pop in the same cycle does not free space for a push that cycle.
- ext_in is registered. It holds the head entry. It updates on the clk edge after the head changes (push into empty queue: visible 1 cycle after the push edge). When the queue becomes empty, ext_in holds the last popped value and is not zeroed.
- in_rd with count>0: pop the head; the next entry appears on ext_in the following cycle. in_rd with count=0: no pop, in_underflow<=1. Simultaneous push and pop on a non-full, non-empty queue: count unchanged, both pointers advance. Push and in_rd on an empty queue: push accepted, underflow set, pushed byte not popped.
- Output capture: on an out_wr edge, ext_out is written into the output queue if not full. If full, the byte is dropped and out_overflow<=1. A captured byte is visible on host_out_valid/host_out_data on the next cycle.
- host_out_valid = (out count != 0); host_out_data = head entry, stable while valid && !ready. A pop happens on valid && ready. Capture and pop in the same cycle are both honoured, even when full: the pop frees the slot and the capture is not dropped.
- Sticky flags clear only on reset.

Optional Feature:
SCPU_PORT_CHANGE_CAPTURE_EN
- Defined: in addition to out_wr, a capture is triggered whenever ext_out differs from the value registered the previous cycle (change detect). The previous-value register resets to 0, so the first nonzero value is captured. out_wr and change detect in the same cycle produce one capture only.
- Undefined: capture only on out_wr; no previous-value register is synthesized.

Decomposition:
- Package scpu_port_pkg: WIDTH default, DEPTH default, a byte typedef, and reset constant EXT_IN_RST = 0.
- One sub-module: scpu_port_fifo (sync FIFO; push/pop/full/empty/count; registered head), instantiated twice. Only the capture path and the change detect live in the top.

Test Plan:
1. Reset then push 0x0F, 0x22 -> host_in_ready stays 1; ext_in=0x0F one cycle after the first push; in_rd pulse -> ext_in=0x22 next cycle; second in_rd -> in_empty=1, ext_in holds 0x22.
2. Push DEPTH=4 bytes 0x01..0x04 with no in_rd -> host_in_ready=0 after the 4th; a 5th offered byte is not accepted; push plus in_rd on a full queue -> pop only; ready=1 the next cycle.
3. in_rd on an empty queue -> in_underflow=1 and stays 1; ext_in unchanged.
4. out_wr with ext_out=0xA5, then 0x3C, host_out_ready=0 -> host_out_valid=1, host_out_data=0xA5 held; ready=1 -> 0xA5 then 0x3C, then valid=0.
5. Fill the output queue (4 captures), a 5th out_wr with 0x77 -> out_overflow=1 and 0x77 absent. Repeat with host_out_ready=1 on the 5th capture -> no overflow, 0x77 retained.
6. With SCPU_PORT_CHANGE_CAPTURE_EN: ext_out steps 0x00->0x10->0x10->0x20, no out_wr -> exactly 0x10 and 0x20 captured. Without the macro -> nothing captured.
7. Assert rst mid-stream with both queues partly full -> all outputs return to reset values immediately, without waiting for a clock edge.
